// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths, the reset fetch address and
// the FIFO occupancy-counter sizing helper.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 7;
  localparam int unsigned CPU_DATA_W = 32;
  localparam int unsigned RESET_PC   = 0;

  // Bits needed to count 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding fetched (pc, instruction) pairs; flush empties it
// in one cycle and takes priority over push/pop.
module fetch_buf import cpu_pkg::*; #(
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CNT_W = cnt_width(DEPTH),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_instr,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head_instr,
  output logic [ADDR_W-1:0] head_pc
);

  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        instr_q[wr_ptr] <= push_instr;
        pc_q[wr_ptr]    <= push_pc;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head_instr = instr_q[rd_ptr];
    head_pc    = pc_q[rd_ptr];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: streams sequential word addresses to a 1-cycle registered
// instruction memory and queues the returned words for a valid/ready consumer.
module instr_fetch import cpu_pkg::*; #(
  parameter int unsigned ADDR_W    = CPU_ADDR_W,
  parameter int unsigned DATA_W    = CPU_DATA_W,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] out_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_valid,
  input  logic              fetch_ready,
  output logic [DATA_W-1:0] fetch_instr,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int unsigned CNT_W = cnt_width(BUF_DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic              issue;
  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;

  // Occupancy counts the in-flight word so the buffer can never overflow,
  // while crediting this cycle's pop keeps throughput at one per cycle.
  always_comb begin
    instr_addr  = pc;
    fetch_valid = (count != '0);
    pop         = fetch_valid && fetch_ready;
    push        = inflight && !redirect_valid;
    occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    issue       = !redirect_valid && (occupancy < (CNT_W + 1)'(BUF_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= ADDR_W'(RESET_PC);
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc <= pc + 1'b1;
      end
      inflight <= issue;
      if (issue) begin
        req_pc <= pc;
      end
    end
  end

  fetch_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_instr (out_instr),
    .push_pc    (req_pc),
    .pop        (pop),
    .flush      (redirect_valid),
    .count      (count),
    .head_instr (fetch_instr),
    .head_pc    (fetch_pc)
  );

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, word-address width of the instruction memory.
REQ-002 The block SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 The block SHALL have parameter BUF_DEPTH, default 2, output buffer entries; legal minimum 2.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port instr_addr  output  ADDR_W  word address driven to instruction memory.
REQ-007 The block SHALL have port out_instr  input  DATA_W  memory read data; registered, valid one cycle after instr_addr.
REQ-008 The block SHALL have port redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-009 The block SHALL have port redirect_pc  input  ADDR_W  restart word address.
REQ-010 The block SHALL have port fetch_valid  output  1  fetch_instr/fetch_pc hold a valid instruction.
REQ-011 The block SHALL have port fetch_ready  input  1  consumer accepts; transfer when fetch_valid && fetch_ready.
REQ-012 The block SHALL have port fetch_instr  output  DATA_W  instruction at buffer head.
REQ-013 The block SHALL have port fetch_pc  output  ADDR_W  word address of fetch_instr.

Function
REQ-014 The block SHALL hold pc; instr_addr SHALL equal pc combinationally every cycle.
REQ-015 An issue SHALL occur in a cycle when (count + inflight - pop) < BUF_DEPTH and redirect_valid is 0; pop = fetch_valid && fetch_ready.
REQ-016 On issue, pc SHALL increment by 1 modulo 2^ADDR_W (127 wraps to 0) and inflight SHALL be set with req_pc = pc; otherwise inflight SHALL clear.
REQ-017 When inflight is set, out_instr SHALL be written with req_pc into the buffer tail on that cycle's edge.
REQ-018 Issue-to-fetch_valid latency SHALL be 2 cycles; sustained throughput SHALL be 1 instruction/cycle with fetch_ready held high.
REQ-019 When not issuing, pc SHALL hold; memory re-reads of an unissued address SHALL be discarded.
REQ-020 fetch_valid SHALL be (count != 0); fetch_instr/fetch_pc SHALL be buffer head and stable while fetch_valid && !fetch_ready.
REQ-021 The buffer SHALL never overflow; simultaneous push and pop SHALL keep count unchanged.
REQ-022 On redirect_valid: pc <= redirect_pc, inflight cleared, buffer emptied, no issue that cycle; first issue of redirect_pc in the following cycle.
REQ-023 A pop coinciding with redirect_valid SHALL complete (instruction consumed), then flush.
REQ-024 Consecutive redirect_valid cycles SHALL each take effect; last one wins.
REQ-025 Data arriving for a squashed inflight request SHALL NOT enter the buffer.

Reset
REQ-026 On rst_n low, asynchronously: pc=0, inflight=0, count=0, buffer pointers=0, fetch_valid=0, fetch_instr=0, fetch_pc=0.
REQ-027 First issue (address 0) SHALL occur in the first cycle after rst_n deasserts.
REQ-028 Reset mid-stream SHALL discard all buffered and inflight instructions.

Structure
REQ-029 ADDR_W, DATA_W defaults and the reset PC SHALL live in shared package cpu_pkg.
REQ-030 Buffer SHALL be sub-module fetch_buf (synchronous FIFO, push/pop/flush, count, head data).

Verification
REQ-031 Reset release, mem[0]=E3A00000, mem[1]=E1A0100F, ready=1 -> fetch_valid rises cycle 2; (pc 0, E3A00000) then (pc 1, E1A0100F) on consecutive cycles.
REQ-032 ready=0 for 5 cycles after first valid -> pc stops after buffer full (count 2), fetch_instr stays E3A00000, no loss/duplication on resume.
REQ-033 redirect_valid, redirect_pc=4 while pc=7 -> buffer flushed, next delivered pair is (pc 4, 1AFFFFFC), no pc 5-7 instructions before it.
REQ-034 Redirect to 127, ready=1 -> delivered pcs 127, 0, 1 in order.
REQ-035 Redirect asserted same cycle as a transfer -> that instruction counted delivered exactly once; next is redirect target.
REQ-036 rst_n pulsed low mid-stream with count=2 -> fetch_valid=0 immediately; restart from pc 0.
